debounce_multi: RTL and testbench

- Parametrised successor to the single-input switch debouncer: WIDTH independent channels.
- Each channel has:
  - a 2-flop synchroniser for asynchronous inputs;
  - a per-channel stability counter;
  - registered rise/fall pulses;
  - a long-press "held" flag.
- Sits between board pushbuttons/switches and the control FSMs. All outputs are synchronous to clk.

---
 rtl/debounce_multi.sv | 95 +++++++++
 tb/tb_debounce_multi.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/debounce_multi.sv
// Multi-channel switch debouncer: per-channel 2-flop synchroniser, stability
// counter, registered rise/fall pulses and a long-press "held" flag.
module debounce_multi #(
    parameter int               WIDTH     = 4,
    parameter int               DELAY     = 270000,
    parameter int               HOLD      = 27000000,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             g_reset,
    input  logic [WIDTH-1:0] noisy,
    output logic [WIDTH-1:0] clean,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic [WIDTH-1:0] held,
    output logic             any_event
);

    localparam int CW = (DELAY < 2) ? 1 : $clog2(DELAY + 1);
    localparam int HW = (HOLD < 2) ? 1 : $clog2(HOLD + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DELAY - 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [CW-1:0]    cnt_q  [WIDTH];
    logic [CW-1:0]    cnt_d  [WIDTH];
    logic [HW-1:0]    hcnt_q [WIDTH];
    logic [HW-1:0]    hcnt_d [WIDTH];
    logic [WIDTH-1:0] clean_d;
    logic [WIDTH-1:0] rise_d;
    logic [WIDTH-1:0] fall_d;
    logic [WIDTH-1:0] held_d;

    // NOTE: every always_comb output gets a default before any branch, so no
    // path leaves a value unassigned and no latch is inferred.
    always_comb begin
        clean_d = clean;
        rise_d  = '0;
        fall_d  = '0;
        held_d  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i]  = '0;
            hcnt_d[i] = '0;
            if (sync2[i] != clean[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    clean_d[i] = sync2[i];
                    rise_d[i]  = sync2[i];
                    fall_d[i]  = ~sync2[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
            // Hold time counts edges where clean stays high; it clears on the
            // same edge clean falls so held drops together with the fall pulse.
            if ((HOLD > 0) && clean[i] && clean_d[i]) begin
                hcnt_d[i] = (hcnt_q[i] == HOLD_MAX) ? HOLD_MAX : hcnt_q[i] + HW'(1);
            end
            held_d[i] = (HOLD > 0) && clean_d[i] && (hcnt_d[i] == HOLD_MAX);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge g_reset) begin
        if (!g_reset) begin
            sync1     <= RESET_VAL;
            sync2     <= RESET_VAL;
            clean     <= RESET_VAL;
            rise      <= '0;
            fall      <= '0;
            held      <= '0;
            any_event <= 1'b0;
            // NOTE: the counter arrays are real state and must be reset; a
            // stale count would shorten the first debounce after reset.
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i]  <= '0;
                hcnt_q[i] <= '0;
            end
        end else begin
            sync1     <= noisy;
            sync2     <= sync1;
            clean     <= clean_d;
            rise      <= rise_d;
            fall      <= fall_d;
            held      <= held_d;
            any_event <= |(rise_d | fall_d);
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i]  <= cnt_d[i];
                hcnt_q[i] <= hcnt_d[i];
            end
        end
    end

endmodule

// File: tb/tb_debounce_multi.sv
// Self-checking bench for debounce_multi: directed scenarios plus random noise,
// compared against a history-window reference model for two reset values.
module tb_debounce_multi;

    localparam int W = 2;
    localparam int D = 4;
    localparam int H = 10;

    logic         clk;
    logic         g_reset;
    logic [W-1:0] noisy;
    logic [W-1:0] clean_a, rise_a, fall_a, held_a;
    logic [W-1:0] clean_b, rise_b, fall_b, held_b;
    logic         any_a, any_b;

    int checks = 0;
    int errors = 0;

    debounce_multi #(.WIDTH(W), .DELAY(D), .HOLD(H), .RESET_VAL(2'b00)) dut_a (
        .clk(clk), .g_reset(g_reset), .noisy(noisy),
        .clean(clean_a), .rise(rise_a), .fall(fall_a), .held(held_a),
        .any_event(any_a)
    );

    debounce_multi #(.WIDTH(W), .DELAY(D), .HOLD(H), .RESET_VAL(2'b11)) dut_b (
        .clk(clk), .g_reset(g_reset), .noisy(noisy),
        .clean(clean_b), .rise(rise_b), .fall(fall_b), .held(held_b),
        .any_event(any_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: clean flips when the last D synchronised samples all
    // disagree with it; held is high once clean has been 1 for H edges.
    logic [W-1:0] m_s1    [2];
    logic [W-1:0] m_s2    [2];
    logic [W-1:0] m_hist  [2][D];
    int           m_fill  [2];
    int           m_edge  [2];
    int           m_rose  [2][W];
    logic [W-1:0] m_clean [2];
    logic [W-1:0] m_rise  [2];
    logic [W-1:0] m_fall  [2];
    logic [W-1:0] m_held  [2];
    logic         m_any   [2];

    function automatic logic [W-1:0] rv(int m);
        return (m == 0) ? 2'b00 : 2'b11;
    endfunction

    always @(posedge clk or negedge g_reset) begin
        logic [W-1:0] used;
        logic         all_diff;
        for (int m = 0; m < 2; m++) begin
            if (!g_reset) begin
                m_s1[m] = rv(m);
                m_s2[m] = rv(m);
                m_clean[m] = rv(m);
                m_fill[m] = 0;
                m_edge[m] = 0;
                for (int i = 0; i < W; i++) m_rose[m][i] = 0;
                m_rise[m] = '0;
                m_fall[m] = '0;
                m_held[m] = '0;
                m_any[m]  = 1'b0;
            end else begin
                used = m_s2[m];
                m_s2[m] = m_s1[m];
                m_s1[m] = noisy;
                for (int k = D - 1; k > 0; k--) m_hist[m][k] = m_hist[m][k-1];
                m_hist[m][0] = used;
                if (m_fill[m] < D) m_fill[m]++;
                m_edge[m]++;
                m_rise[m] = '0;
                m_fall[m] = '0;
                for (int i = 0; i < W; i++) begin
                    all_diff = (m_fill[m] >= D);
                    for (int k = 0; k < D; k++)
                        if (m_hist[m][k][i] == m_clean[m][i]) all_diff = 1'b0;
                    if (all_diff) begin
                        m_clean[m][i] = ~m_clean[m][i];
                        if (m_clean[m][i]) begin
                            m_rise[m][i] = 1'b1;
                            m_rose[m][i] = m_edge[m];
                        end else begin
                            m_fall[m][i] = 1'b1;
                        end
                    end
                    m_held[m][i] = (H > 0) && m_clean[m][i] && (m_edge[m] - m_rose[m][i] >= H);
                end
                m_any[m] = |(m_rise[m] | m_fall[m]);
            end
        end
    end

    task automatic cmp(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        cmp("clean_a", clean_a, m_clean[0]);
        cmp("rise_a",  rise_a,  m_rise[0]);
        cmp("fall_a",  fall_a,  m_fall[0]);
        cmp("held_a",  held_a,  m_held[0]);
        cmp("any_a",   {1'b0, any_a}, {1'b0, m_any[0]});
        cmp("excl_a",  rise_a & fall_a, 2'b00);
        cmp("clean_b", clean_b, m_clean[1]);
        cmp("rise_b",  rise_b,  m_rise[1]);
        cmp("fall_b",  fall_b,  m_fall[1]);
        cmp("held_b",  held_b,  m_held[1]);
        cmp("any_b",   {1'b0, any_b}, {1'b0, m_any[1]});
        cmp("excl_b",  rise_b & fall_b, 2'b00);
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
            check_all();
        end
    endtask

    task automatic async_reset_pulse();
        #2 g_reset = 1'b0;
        #1;
        cmp("rst_clean_a", clean_a, 2'b00);
        cmp("rst_puls_a",  rise_a | fall_a | held_a, 2'b00);
        cmp("rst_any_a",   {1'b0, any_a}, 2'b00);
        cmp("rst_clean_b", clean_b, 2'b11);
        cmp("rst_held_b",  held_b, 2'b00);
        check_all();
    endtask

    initial begin
        logic [W-1:0] b_pulse;
        g_reset = 1'b0;
        noisy   = 2'b00;
        repeat (2) @(negedge clk);
        check_all();
        g_reset = 1'b1;

        // Idle after reset
        cyc(20);
        cmp("idle_clean_a", clean_a, 2'b00);

        // Clean step on channel 0: flips on the 6th edge, pulse lasts one cycle
        noisy[0] = 1'b1;
        cyc(5);
        cmp("lat_pre", clean_a, 2'b00);
        cyc(1);
        cmp("lat_clean", clean_a, 2'b01);
        cmp("lat_rise",  rise_a,  2'b01);
        cmp("lat_any",   {1'b0, any_a}, 2'b01);
        cyc(1);
        cmp("lat_rise_end", rise_a, 2'b00);

        // Glitches on channel 1 shorter than DELAY
        noisy[1] = 1'b1; cyc(3);
        for (int k = 0; k < 4; k++) begin
            noisy[1] = ~noisy[1];
            cyc(2);
        end
        noisy[1] = 1'b0; cyc(6);
        cmp("glitch_clean", clean_a[1], 1'b0);
        noisy[1] = 1'b1; cyc(4);
        noisy[1] = 1'b0; cyc(12);

        // Held on channel 0 then release
        cmp("held_on", held_a, 2'b01);
        noisy[0] = 1'b0;
        cyc(10);

        // Simultaneous step on both channels
        noisy = 2'b11;
        cyc(20);
        cmp("both_held", held_a, 2'b11);
        noisy = 2'b00;
        cyc(4);

        // Async reset mid-count, then release with noisy=11
        async_reset_pulse();
        noisy = 2'b11;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        g_reset = 1'b1;
        b_pulse = '0;
        for (int e = 1; e <= 6; e++) begin
            @(posedge clk);
            @(negedge clk);
            check_all();
            b_pulse = b_pulse | rise_b | fall_b;
            if (e < 6) cmp("rel_early", rise_a, 2'b00);
        end
        cmp("rel_rise", rise_a, 2'b11);
        cmp("rel_any",  {1'b0, any_a}, 2'b01);
        cmp("rel_b_quiet", b_pulse, 2'b00);
        cyc(1);
        cmp("rel_rise_end", rise_a, 2'b00);

        // Random noise with mixed short and long segments
        for (int s = 0; s < 150; s++) begin
            noisy = W'($urandom_range(0, 3));
            cyc($urandom_range(1, (s % 5 == 0) ? 20 : 7));
            if (s == 75) begin
                async_reset_pulse();
                @(negedge clk);
                g_reset = 1'b1;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
